// File: rtl/ir_sense.sv
// IR sensor sampler: sequences two A2D conversions per period, registers left/right
// readings with hysteretic open flags and a saturated derivative of their difference.
`timescale 1ns/1ps
module ir_sense #(
  parameter logic [2:0]  LFT_CHNL   = 3'd0,
  parameter logic [2:0]  RGHT_CHNL  = 3'd4,
  parameter logic [15:0] SAMPLE_PER = 16'd50000,
  parameter logic [11:0] OPN_LO     = 12'h300,
  parameter logic [11:0] CLS_HI     = 12'h400,
  parameter int          DTRM_DEPTH = 4,
  parameter logic [15:0] CNV_TMO    = 16'd2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] lft_IR,
  output logic [11:0] rght_IR,
  output logic        lft_opn,
  output logic        rght_opn,
  output logic [8:0]  IR_Dtrm,
  output logic        IR_vld,
  output logic        cnv_err
);

  typedef enum logic [2:0] {IDLE, CNV_L, WAIT_L, CNV_R, WAIT_R, UPD} state_t;

  localparam logic [3:0] DEPTH_CNT = 4'(DTRM_DEPTH);

  state_t             state_reg, state_next;
  logic [15:0]        per_cnt_reg;
  logic [15:0]        tmo_cnt_reg;
  logic [11:0]        lft_tmp_reg;
  logic [3:0]         rnd_cnt_reg;
  logic [11:0]        lft_ir_reg, rght_ir_reg;
  logic               lft_opn_reg, rght_opn_reg;
  logic [8:0]         dtrm_reg;
  logic               cnv_err_reg;

  logic               tick;
  logic               in_wait;
  logic               tmo_hit;
  logic               upd_en;
  logic               lft_opn_next, rght_opn_next;
  logic signed [12:0] d_now;
  logic signed [12:0] d_old;
  logic signed [13:0] d_diff;
  logic signed [13:0] d_shr;
  logic signed [8:0]  d_sat;
  logic [8:0]         dtrm_next;

  assign tick    = (per_cnt_reg == 16'd0);
  assign in_wait = (state_reg == WAIT_L) || (state_reg == WAIT_R);
  assign tmo_hit = in_wait && !cnv_cmplt && (tmo_cnt_reg == CNV_TMO - 16'd1);
  // Outputs load on the right-channel completion so they are valid while IR_vld is high.
  assign upd_en  = (state_reg == WAIT_R) && cnv_cmplt;

  always_comb begin
    state_next = state_reg;
    strt_cnv   = 1'b0;
    chnnl      = LFT_CHNL;
    case (state_reg)
      IDLE:   if (tick && en) state_next = CNV_L;
      CNV_L: begin
        strt_cnv   = 1'b1;
        state_next = WAIT_L;
      end
      WAIT_L: begin
        if (cnv_cmplt)    state_next = CNV_R;
        else if (tmo_hit) state_next = IDLE;
      end
      CNV_R: begin
        strt_cnv   = 1'b1;
        chnnl      = RGHT_CHNL;
        state_next = WAIT_R;
      end
      WAIT_R: begin
        chnnl = RGHT_CHNL;
        if (cnv_cmplt)    state_next = UPD;
        else if (tmo_hit) state_next = IDLE;
      end
      UPD:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      per_cnt_reg <= SAMPLE_PER - 16'd1;
      tmo_cnt_reg <= 16'd0;
      lft_tmp_reg <= 12'd0;
      cnv_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      per_cnt_reg <= tick ? (SAMPLE_PER - 16'd1) : (per_cnt_reg - 16'd1);
      tmo_cnt_reg <= in_wait ? (tmo_cnt_reg + 16'd1) : 16'd0;
      if ((state_reg == WAIT_L) && cnv_cmplt) lft_tmp_reg <= res;
      if (tmo_hit) cnv_err_reg <= 1'b1;
    end
  end

  // Open flags hold their previous value inside the hysteresis band, thresholds included.
  always_comb begin
    lft_opn_next = lft_opn_reg;
    if (lft_tmp_reg < OPN_LO)      lft_opn_next = 1'b1;
    else if (lft_tmp_reg > CLS_HI) lft_opn_next = 1'b0;
    rght_opn_next = rght_opn_reg;
    if (res < OPN_LO)              rght_opn_next = 1'b1;
    else if (res > CLS_HI)         rght_opn_next = 1'b0;
  end

  // History of past differences; element 0 is the newest.
  for (genvar gi = 0; gi < DTRM_DEPTH; gi++) begin : g_hist
    logic signed [12:0] h_reg;
    always_ff @(posedge clk) begin
      if (rst)         h_reg <= '0;
      else if (upd_en) begin
        if (gi == 0)   h_reg <= d_now;
        else           h_reg <= g_hist[(gi == 0) ? 0 : gi - 1].h_reg;
      end
    end
  end

  assign d_now  = $signed({1'b0, lft_tmp_reg}) - $signed({1'b0, res});
  assign d_old  = g_hist[DTRM_DEPTH-1].h_reg;
  assign d_diff = $signed({d_now[12], d_now}) - $signed({d_old[12], d_old});
  assign d_shr  = d_diff >>> 2;

  always_comb begin
    if (d_shr > 14'sd255)        d_sat = 9'sd255;
    else if (d_shr < -14'sd256)  d_sat = -9'sd256;
    else                         d_sat = d_shr[8:0];
    dtrm_next = 9'd0;
    if ((rnd_cnt_reg == DEPTH_CNT) && !lft_opn_next && !rght_opn_next)
      dtrm_next = d_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_ir_reg   <= 12'd0;
      rght_ir_reg  <= 12'd0;
      lft_opn_reg  <= 1'b1;
      rght_opn_reg <= 1'b1;
      dtrm_reg     <= 9'd0;
      rnd_cnt_reg  <= 4'd0;
    end else if (upd_en) begin
      lft_ir_reg   <= lft_tmp_reg;
      rght_ir_reg  <= res;
      lft_opn_reg  <= lft_opn_next;
      rght_opn_reg <= rght_opn_next;
      dtrm_reg     <= dtrm_next;
      if (rnd_cnt_reg != DEPTH_CNT) rnd_cnt_reg <= rnd_cnt_reg + 4'd1;
    end
  end

  assign lft_IR   = lft_ir_reg;
  assign rght_IR  = rght_ir_reg;
  assign lft_opn  = lft_opn_reg;
  assign rght_opn = rght_opn_reg;
  assign IR_Dtrm  = dtrm_reg;
  assign IR_vld   = (state_reg == UPD);
  assign cnv_err  = cnv_err_reg;

endmodule
